ex_mem_latch: RTL

- Pipeline register between the EX stage and the MEM stage.
- Captures EX results and the control word, and holds them while the data cache is servicing a load or store or while the pipeline is globally stalled.
- Squashes wrong-path instructions when MEM resolves a taken branch or jump.
- Runs a small access FSM so each load or store is issued to the cache exactly once. After the cache responds, load data is held stable for as long as the stage stays frozen.

---
 rtl/ex_mem_latch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with a one-shot data-cache access FSM.
// Holds its contents while the cache is busy or the pipeline is globally stalled.
package rv32i_types;
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       MEM_Read;
        logic       MEM_Write;
        logic       mem_to_reg;
        logic       reg_write;
    } rv32i_control_word;
endpackage

module ex_mem_latch
    import rv32i_types::*;
#(
    parameter logic PERF_CNT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_valid,
    input  rv32i_control_word EX_control,
    input  logic [31:0]       EX_RESULT,
    input  logic [31:0]       EX_ALU_IN1,
    input  logic [31:0]       EX_ALU_IN2,
    input  logic [31:0]       EX_ADD,
    input  logic              EX_ZERO,
    input  logic [4:0]        EX_RD,
    input  logic [4:0]        EX_RS1,
    input  logic [4:0]        EX_RS2,
    input  logic [3:0]        EX_funct,
    input  logic              MEM_resp,
    input  logic [31:0]       MEM_Load_Data_live,
    input  logic              PCSrc,
    input  logic              stall_in,
    output logic              MEM_valid,
    output rv32i_control_word MEM_control,
    output logic [31:0]       MEM_RESULT,
    output logic [31:0]       MEM_ALU_IN1,
    output logic [31:0]       MEM_ALU_IN2,
    output logic [31:0]       MEM_ADD,
    output logic              MEM_ZERO,
    output logic [4:0]        MEM_RD,
    output logic [4:0]        MEM_RS1,
    output logic [4:0]        MEM_RS2,
    output logic [3:0]        MEM_funct,
    output logic [31:0]       MEM_Load_Data,
    output logic              mem_stall,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state;
    rv32i_control_word ctrl_q;
    logic              valid_q;
    logic [31:0]       held_q;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
    logic              hold;
    logic              ex_memop;

    assign hold      = stall_in | (state == WAIT && !MEM_resp) | (state == DONE && stall_in);
    assign ex_memop  = EX_valid & (EX_control.MEM_Read | EX_control.MEM_Write);
    assign mem_stall = hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            MEM_RESULT  <= '0;
            MEM_ALU_IN1 <= '0;
            MEM_ALU_IN2 <= '0;
            MEM_ADD     <= '0;
            MEM_ZERO    <= 1'b0;
            MEM_RD      <= '0;
            MEM_RS1     <= '0;
            MEM_RS2     <= '0;
            MEM_funct   <= '0;
            held_q      <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (hold)
                stall_cnt <= stall_cnt + 32'd1;
            if (!hold) begin
                if (PCSrc) begin
                    // wrong-path squash: bubble in, fields zeroed
                    state       <= IDLE;
                    valid_q     <= 1'b0;
                    ctrl_q      <= '0;
                    MEM_RESULT  <= '0;
                    MEM_ALU_IN1 <= '0;
                    MEM_ALU_IN2 <= '0;
                    MEM_ADD     <= '0;
                    MEM_ZERO    <= 1'b0;
                    MEM_RD      <= '0;
                    MEM_RS1     <= '0;
                    MEM_RS2     <= '0;
                    MEM_funct   <= '0;
                    if (EX_valid)
                        flush_cnt <= flush_cnt + 32'd1;
                end else begin
                    state       <= ex_memop ? WAIT : IDLE;
                    valid_q     <= EX_valid;
                    ctrl_q      <= EX_control;
                    MEM_RESULT  <= EX_RESULT;
                    MEM_ALU_IN1 <= EX_ALU_IN1;
                    MEM_ALU_IN2 <= EX_ALU_IN2;
                    MEM_ADD     <= EX_ADD;
                    MEM_ZERO    <= EX_ZERO;
                    MEM_RD      <= EX_RD;
                    MEM_RS1     <= EX_RS1;
                    MEM_RS2     <= EX_RS2;
                    MEM_funct   <= EX_funct;
                end
            end else if (state == WAIT && MEM_resp) begin
                // response arrived while frozen: keep the load data for the wait
                state  <= DONE;
                held_q <= MEM_Load_Data_live;
            end
        end
    end

    // Read/Write only visible while the access is outstanding, so it is issued once
    always_comb begin
        MEM_control = '0;
        if (valid_q) begin
            MEM_control           = ctrl_q;
            MEM_control.MEM_Read  = ctrl_q.MEM_Read  & (state == WAIT);
            MEM_control.MEM_Write = ctrl_q.MEM_Write & (state == WAIT);
        end
    end

    assign MEM_valid     = valid_q;
    assign MEM_Load_Data = (state == DONE) ? held_q : MEM_Load_Data_live;
    assign stall_cycles  = PERF_CNT ? stall_cnt : 32'd0;
    assign flush_count   = PERF_CNT ? flush_cnt : 32'd0;

endmodule
